// File: rtl/seg_capture.sv
// Captures hex digits from a multiplexed active-low 7-segment scan bus.
// Each digit must hold steady for STABLE_CYCLES samples before it is decoded.
module seg_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  anode,
  input  logic [6:0]  segments,
  input  logic        clear,
  output logic [31:0] digits,
  output logic [7:0]  digit_valid,
  output logic        frame_done,
  output logic        err_pattern,
  output logic        err_anode
);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  localparam logic [7:0]  CNT_MAX    = 8'(STABLE_CYCLES - 1);
  localparam logic [14:0] SAMPLE_RST = {8'hFF, 7'h7F};

  state_t      state_q;
  logic [14:0] sample_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        multi_q;
  logic        acc_q, accOk_q;
  logic [2:0]  accIdx_q;
  logic [3:0]  accNib_q;
  logic [31:0] digits_q;
  logic [7:0]  valid_q, valid_d;
  logic        frame_q, errPat_q, errAn_q;

  logic [7:0]  sampleAn;
  logic [6:0]  sampleSeg;
  logic        anLegal, anMulti;
  logic [4:0]  decoded;

  // Position of the single low bit in a legal anode pattern.
  function automatic logic [2:0] lowIndex(input logic [7:0] an);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!an[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Returns {legal, nibble} for an active-low gfedcba pattern.
  function automatic logic [4:0] decodeSeg(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40: r = 5'h10;  7'h79: r = 5'h11;  7'h24: r = 5'h12;  7'h30: r = 5'h13;
      7'h19: r = 5'h14;  7'h12: r = 5'h15;  7'h02: r = 5'h16;  7'h78: r = 5'h17;
      7'h00: r = 5'h18;  7'h10: r = 5'h19;  7'h08: r = 5'h1A;  7'h03: r = 5'h1B;
      7'h46: r = 5'h1C;  7'h21: r = 5'h1D;  7'h06: r = 5'h1E;  7'h0E: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  assign sampleAn  = sample_q[14:7];
  assign sampleSeg = sample_q[6:0];
  assign anLegal   = ($countones(~sampleAn) == 1);
  assign anMulti   = ($countones(~sampleAn) > 1);
  assign decoded   = decodeSeg(sampleSeg);

  always_comb begin
    cnt_d = cnt_q;
    if ({anode, segments} != sample_q) cnt_d = 8'd0;
    else if (cnt_q != CNT_MAX)         cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q <= SAMPLE_RST;
      cnt_q    <= 8'd0;
    end else begin
      sample_q <= {anode, segments};
      cnt_q    <= cnt_d;
    end
  end

  // cnt_q == 0 marks a sample that differs from its predecessor.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= 1'b0;
      accOk_q  <= 1'b0;
      accIdx_q <= 3'd0;
      accNib_q <= 4'd0;
    end else begin
      acc_q <= 1'b0;
      if (!anLegal) begin
        state_q <= IDLE;
      end else if (state_q == IDLE || cnt_q == 8'd0) begin
        state_q <= SETTLE;
      end else if (state_q == SETTLE && cnt_q == CNT_MAX) begin
        state_q  <= HELD;
        acc_q    <= 1'b1;
        accOk_q  <= decoded[4];
        accNib_q <= decoded[3:0];
        accIdx_q <= lowIndex(sampleAn);
      end
    end
  end

  assign valid_d = valid_q | (8'd1 << accIdx_q);

  // Clear overrides a coincident capture, including its frame_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q <= 32'd0;
      valid_q  <= 8'd0;
      frame_q  <= 1'b0;
      errPat_q <= 1'b0;
      errAn_q  <= 1'b0;
      multi_q  <= 1'b0;
    end else begin
      frame_q  <= 1'b0;
      errPat_q <= acc_q && !accOk_q;
      errAn_q  <= anMulti && !multi_q;
      multi_q  <= anMulti;
      if (clear) begin
        digits_q <= 32'd0;
        valid_q  <= 8'd0;
      end else if (acc_q && accOk_q) begin
        digits_q[{accIdx_q, 2'b00} +: 4] <= accNib_q;
        valid_q <= valid_d;
        frame_q <= (&valid_d) && !(&valid_q);
      end
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign frame_done  = frame_q;
  assign err_pattern = errPat_q;
  assign err_anode   = errAn_q;

endmodule

// File: tb/tb_seg_capture.sv
// Randomized and directed bench for seg_capture against a run-length model
// of the scan bus: a legal run of STABLE_CYCLES identical inputs captures once.
module tb_seg_capture;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst, clear;
  logic [7:0]  anode;
  logic [6:0]  segments;
  logic [31:0] digits;
  logic [7:0]  digit_valid;
  logic        frame_done, err_pattern, err_anode;

  seg_capture #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .anode(anode), .segments(segments), .clear(clear),
    .digits(digits), .digit_valid(digit_valid), .frame_done(frame_done),
    .err_pattern(err_pattern), .err_anode(err_anode)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int frameCount, errPatCount, errAnCount;

  logic [6:0] segTable [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state.
  typedef struct {int due; bit ok; int idx; logic [3:0] nib;} acc_t;
  acc_t        pend[$];
  int          cyc = 0;
  int          runStart = 0;
  logic [14:0] prevIn = {8'hFF, 7'h7F};
  logic [31:0] mDigits = '0;
  logic [7:0]  mValid = '0;
  bit          mFrame, mErrPat, mErrAn, errAnNext;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  function automatic int lowCount(input logic [7:0] an);
    int n = 0;
    for (int i = 0; i < 8; i++) if (!an[i]) n++;
    return n;
  endfunction

  task automatic modelStep();
    acc_t        a;
    logic [14:0] cur;
    bit          wasAll;
    cyc++;
    cur = {anode, segments};
    if (rst) begin
      mDigits = '0; mValid = '0; mFrame = 0; mErrPat = 0; mErrAn = 0; errAnNext = 0;
      pend.delete();
      prevIn = {8'hFF, 7'h7F};
      runStart = cyc;
      return;
    end
    mFrame = 0; mErrPat = 0; mErrAn = errAnNext;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      a = pend.pop_front();
      if (!a.ok) mErrPat = 1;
      else if (!clear) begin
        wasAll = &mValid;
        mValid[a.idx] = 1'b1;
        mDigits[a.idx*4 +: 4] = a.nib;
        mFrame = !wasAll && (&mValid);
      end
    end
    if (clear) begin mDigits = '0; mValid = '0; end
    errAnNext = (lowCount(anode) > 1) && (lowCount(prevIn[14:7]) <= 1);
    if (cur !== prevIn) runStart = cyc;
    prevIn = cur;
    if (cyc - runStart == S - 1 && lowCount(anode) == 1) begin
      a.due = cyc + 2; a.ok = 0; a.nib = 4'd0; a.idx = 0;
      for (int i = 0; i < 8; i++) if (!anode[i]) a.idx = i;
      for (int h = 0; h < 16; h++) if (segTable[h] == segments) begin a.ok = 1; a.nib = 4'(h); end
      pend.push_back(a);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] an, input logic [6:0] sg,
                               input logic clr, input logic rs, input int n);
    anode = an; segments = sg; clear = clr; rst = rs;
    repeat (n) begin
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkOutput("digits", digits, mDigits);
      checkOutput("digit_valid", 32'(digit_valid), 32'(mValid));
      checkOutput("frame_done", 32'(frame_done), 32'(mFrame));
      checkOutput("err_pattern", 32'(err_pattern), 32'(mErrPat));
      checkOutput("err_anode", 32'(err_anode), 32'(mErrAn));
      if (frame_done) frameCount++;
      if (err_pattern) errPatCount++;
      if (err_anode) errAnCount++;
    end
  endtask

  int pi [8] = '{3, 1, 4, 1, 5, 9, 2, 6};

  initial begin
    logic [7:0] an;
    logic [6:0] sg;
    int hold, kind;
    anode = 8'hFF; segments = 7'h7F; clear = 0; rst = 1;
    applyStimulus(8'hFF, 7'h7F, 0, 1, 3);

    // Single stable digit.
    frameCount = 0;
    applyStimulus(8'hFE, 7'h24, 0, 0, 10);
    checkOutput("single_digit", 32'(digits[3:0]), 32'd2);
    checkOutput("single_valid", 32'(digit_valid), 32'h01);

    // Full scan of eight digits.
    applyStimulus(8'hFF, 7'h7F, 1, 0, 1);
    frameCount = 0;
    for (int i = 0; i < 8; i++) applyStimulus(~(8'd1 << i), segTable[pi[i]], 0, 0, 6);
    applyStimulus(8'hFF, 7'h7F, 0, 0, 3);
    checkOutput("scan_digits", digits, 32'h62951413);
    checkOutput("scan_valid", 32'(digit_valid), 32'hFF);
    checkOutput("scan_frames", 32'(frameCount), 32'd1);

    // Bouncing segments never settle.
    applyStimulus(8'hFF, 7'h7F, 1, 0, 1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(8'hFB, 7'h00, 0, 0, 2);
      applyStimulus(8'hFB, 7'h79, 0, 0, 2);
    end
    checkOutput("bounce_valid", 32'(digit_valid), 32'h00);

    // Illegal pattern and multi-low anode.
    errPatCount = 0; errAnCount = 0;
    applyStimulus(8'hFD, 7'h7F, 0, 0, 8);
    checkOutput("badpat_pulses", 32'(errPatCount), 32'd1);
    checkOutput("badpat_valid", 32'(digit_valid), 32'h00);
    applyStimulus(8'hFC, 7'h40, 0, 0, 6);
    checkOutput("badan_pulses", 32'(errAnCount), 32'd1);
    applyStimulus(8'hFF, 7'h7F, 0, 0, 2);

    // Clear on the accept cycle of the last digit.
    frameCount = 0;
    for (int i = 0; i < 7; i++) applyStimulus(~(8'd1 << i), segTable[$urandom_range(0, 15)], 0, 0, 6);
    applyStimulus(8'h7F, 7'h24, 0, 0, 5);
    applyStimulus(8'h7F, 7'h24, 1, 0, 1);
    applyStimulus(8'hFF, 7'h7F, 0, 0, 3);
    checkOutput("clrwin_valid", 32'(digit_valid), 32'h00);
    checkOutput("clrwin_digits", digits, 32'h0);
    checkOutput("clrwin_frames", 32'(frameCount), 32'd0);

    // Reset in the middle of settling.
    applyStimulus(8'hFE, 7'h30, 0, 0, 3);
    applyStimulus(8'hFF, 7'h7F, 0, 1, 1);
    applyStimulus(8'hFF, 7'h7F, 0, 0, 8);
    checkOutput("rstmid_valid", 32'(digit_valid), 32'h00);
    checkOutput("rstmid_digits", digits, 32'h0);

    // Randomized traffic.
    repeat (250) begin
      kind = $urandom_range(0, 9);
      if (kind == 0)      an = 8'hFF;
      else if (kind == 1) an = ~((8'd1 << $urandom_range(0, 7)) | (8'd1 << $urandom_range(0, 7)));
      else                an = ~(8'd1 << $urandom_range(0, 7));
      sg = ($urandom_range(0, 4) == 0) ? 7'($urandom) : segTable[$urandom_range(0, 15)];
      hold = $urandom_range(1, 8);
      if ($urandom_range(0, 49) == 0) applyStimulus(an, sg, 0, 1, 1);
      else if ($urandom_range(0, 19) == 0) applyStimulus(an, sg, 1, 0, 1);
      applyStimulus(an, sg, 0, 0, hold);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
